// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the debounced key report produced by keypad_scanner.
// The scanner takes the master side; the keypad/consumer side takes the slave.
interface keypad_scanner_if;
    logic [3:0] kp_row;
    logic [3:0] kp_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_press;
    logic       key_release;

    modport master (
        input  kp_row,
        output kp_col, key_code, key_valid, key_press, key_release
    );

    modport slave (
        output kp_row,
        input  kp_col, key_code, key_valid, key_press, key_release
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, full-frame capture of the
// rows, and a frame-level debouncer reporting a hex key with press/release pulses.
module keypad_scanner #(
    parameter int unsigned CLK_FREQ       = 32'd100000000,
    parameter int unsigned SCAN_HZ        = 32'd1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp_if
);
    localparam int unsigned TICK_DIV = CLK_FREQ / SCAN_HZ;
    localparam int unsigned TICK_W   = $clog2(TICK_DIV);
    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        FRAME_NONE,
        FRAME_SINGLE,
        FRAME_MULTI
    } frame_cls_e;

    typedef enum logic {
        ST_IDLE,
        ST_HELD
    } deb_state_e;

    function automatic logic [3:0] key_lut(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            4'b11_11: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]        row_meta_q, row_sync_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [3:0]        kp_col_q;
    logic [15:0]       row_buf_q;
    logic              frame_done_q;
    logic              tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_q   <= 4'hF;
            row_sync_q   <= 4'hF;
            tick_cnt_q   <= '0;
            kp_col_q     <= 4'b1110;
            // NOTE: the row buffer is reset because a stale frame would otherwise
            // be classified as a key right after reset.
            row_buf_q    <= 16'hFFFF;
            frame_done_q <= 1'b0;
        end else begin
            row_meta_q   <= kp_if.kp_row;
            row_sync_q   <= row_meta_q;
            tick_cnt_q   <= tick ? '0 : tick_cnt_q + 1'b1;
            frame_done_q <= tick && !kp_col_q[3];
            if (tick) begin
                for (int c = 0; c < 4; c++) begin
                    if (!kp_col_q[c]) row_buf_q[c*4 +: 4] <= row_sync_q;
                end
                kp_col_q <= {kp_col_q[2:0], kp_col_q[3]};
            end
        end
    end

    logic [4:0] low_cnt;
    logic [3:0] low_idx;
    frame_cls_e frame_cls;
    logic [3:0] frame_code;

    // Buffer bit index is col*4+row, so the last low bit decodes straight to a key.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        low_cnt    = '0;
        low_idx    = '0;
        frame_cls  = FRAME_MULTI;
        frame_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (!row_buf_q[i]) begin
                low_cnt = low_cnt + 5'd1;
                low_idx = 4'(i);
            end
        end
        if (low_cnt == 5'd0) begin
            frame_cls = FRAME_NONE;
        end else if (low_cnt == 5'd1) begin
            frame_cls  = FRAME_SINGLE;
            frame_code = key_lut(low_idx[1:0], low_idx[3:2]);
        end
    end

    frame_cls_e       cand_cls_q;
    logic [3:0]       cand_code_q;
    logic [CNT_W-1:0] cand_cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             same_as_cand;

    always_comb begin
        same_as_cand = (frame_cls == cand_cls_q) &&
                       (frame_cls == FRAME_NONE || frame_code == cand_code_q);
        if (!same_as_cand)              cnt_next = CNT_W'(1);
        else if (cand_cnt_q == CNT_SAT) cnt_next = cand_cnt_q;
        else                            cnt_next = cand_cnt_q + 1'b1;
    end

    deb_state_e state_q;
    logic [3:0] key_code_q;
    logic       key_press_q, key_release_q;

    // MULTI frames (ghosting/rollover) are ignored entirely, keeping cand and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_cls_q    <= FRAME_NONE;
            cand_code_q   <= 4'h0;
            cand_cnt_q    <= '0;
            state_q       <= ST_IDLE;
            key_code_q    <= 4'h0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            if (frame_done_q && frame_cls != FRAME_MULTI) begin
                cand_cls_q  <= frame_cls;
                cand_code_q <= frame_code;
                cand_cnt_q  <= cnt_next;
                if (cnt_next == CNT_SAT) begin
                    case (state_q)
                        ST_IDLE: begin
                            if (frame_cls == FRAME_SINGLE) begin
                                state_q     <= ST_HELD;
                                key_code_q  <= frame_code;
                                key_press_q <= 1'b1;
                            end
                        end
                        ST_HELD: begin
                            if (frame_cls == FRAME_NONE) begin
                                state_q       <= ST_IDLE;
                                key_release_q <= 1'b1;
                            end else if (frame_code != key_code_q) begin
                                key_code_q    <= frame_code;
                                key_press_q   <= 1'b1;
                                key_release_q <= 1'b1;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign kp_if.kp_col      = kp_col_q;
    assign kp_if.key_code    = key_code_q;
    assign kp_if.key_valid   = (state_q == ST_HELD);
    assign kp_if.key_press   = key_press_q;
    assign kp_if.key_release = key_release_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the rows, a frame-level
// reference model predicts every output each cycle, and directed checks pin it.
module tb_keypad_scanner;
    localparam int DEB = 3;
    localparam int K1 = 0;   // row0 col0
    localparam int K5 = 5;   // row1 col1
    localparam int K6 = 9;   // row1 col2
    localparam int KA = 12;  // row0 col3
    localparam int KD = 15;  // row3 col3

    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pressed;
    logic [3:0]  row_drive;
    int          n_edges;
    int          vectors = 0;
    int          miscompares = 0;
    int          press_cnt = 0;
    int          release_cnt = 0;

    keypad_scanner_if kp_if ();

    keypad_scanner #(
        .CLK_FREQ       (32'd1000),
        .SCAN_HZ        (32'd100),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp_if (kp_if)
    );

    always #5 clk = ~clk;

    // Pressed key at bit col*4+row pulls its row low while its column is driven low.
    always_comb begin
        row_drive = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!kp_if.kp_col[c] && pressed[c*4+r]) row_drive[r] = 1'b0;
            end
        end
    end
    assign kp_if.kp_row = row_drive;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t n=%0d got %h expected %h", name, $time, n_edges, got, exp);
        end
    endtask

    // Reference model: column k is sampled at edge 10k+8 (two sync flops before the
    // column tick); the frame closes at edge 40f+38 and its result shows 3 edges later.
    initial begin : model
        int n, e, nb, idx, pend_at;
        logic [15:0] frame_low;
        int cand_cls, cand_code, cand_cnt;
        logic exp_valid, exp_press, exp_release;
        logic [3:0] exp_code, exp_col;
        logic pend_valid, pend_press, pend_release;
        logic [3:0] pend_code, code;
        int cls;
        forever begin
            @(negedge clk);
            n = n_edges;
            if (reset) begin
                frame_low = 16'h0;
                cand_cls = 0; cand_code = 0; cand_cnt = 0;
                exp_valid = 1'b0; exp_code = 4'h0;
                exp_press = 1'b0; exp_release = 1'b0;
                pend_at = -1;
                pend_valid = 1'b0; pend_code = 4'h0;
                pend_press = 1'b0; pend_release = 1'b0;
            end else begin
                exp_press = 1'b0;
                exp_release = 1'b0;
                if (n == pend_at) begin
                    exp_valid = pend_valid;
                    exp_code = pend_code;
                    exp_press = pend_press;
                    exp_release = pend_release;
                end
            end
            exp_col = ~(4'b0001 << ((n / 10) % 4));
            check("kp_col", kp_if.kp_col, exp_col);
            check("key_code", kp_if.key_code, exp_code);
            check("key_valid", {3'b0, kp_if.key_valid}, {3'b0, exp_valid});
            check("key_press", {3'b0, kp_if.key_press}, {3'b0, exp_press});
            check("key_release", {3'b0, kp_if.key_release}, {3'b0, exp_release});
            if (kp_if.key_press === 1'b1) press_cnt++;
            if (kp_if.key_release === 1'b1) release_cnt++;

            if (!reset) begin
                e = n + 1;
                if (e % 10 == 8) frame_low[((e / 10) % 4)*4 +: 4] = pressed[((e / 10) % 4)*4 +: 4];
                if (e % 40 == 38) begin
                    nb = 0; idx = 0;
                    for (int i = 0; i < 16; i++) if (frame_low[i]) begin nb++; idx = i; end
                    cls = (nb == 0) ? 0 : (nb == 1) ? 1 : 2;
                    code = (cls == 1) ? KEYMAP[idx % 4][idx / 4] : 4'h0;
                    if (cls != 2) begin
                        if (cls == cand_cls && (cls == 0 || code == cand_code)) begin
                            if (cand_cnt < DEB) cand_cnt++;
                        end else begin
                            cand_cls = cls; cand_code = code; cand_cnt = 1;
                        end
                        pend_valid = exp_valid; pend_code = exp_code;
                        pend_press = 1'b0; pend_release = 1'b0;
                        if (cand_cnt == DEB) begin
                            if (cls == 0 && exp_valid) begin
                                pend_valid = 1'b0; pend_release = 1'b1;
                            end else if (cls == 1 && (!exp_valid || code != exp_code)) begin
                                pend_press = 1'b1; pend_release = exp_valid;
                                pend_valid = 1'b1; pend_code = code;
                            end
                        end
                        pend_at = e + 3;
                    end
                end
            end
        end
    end

    task automatic goto(input int target);
        while (n_edges < target) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        miscompares++;
        $display("FAIL watchdog t=%0t bench did not complete", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : stimulus
        int p0, r0;
        reset = 1'b1;
        pressed = 16'h0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Idle scan: column rotation and no activity
        goto(5);  check("col_c0", kp_if.kp_col, 4'b1110);
        goto(15); check("col_c1", kp_if.kp_col, 4'b1101);
        goto(25); check("col_c2", kp_if.kp_col, 4'b1011);
        goto(35); check("col_c3", kp_if.kp_col, 4'b0111);
        goto(45); check("col_wrap", kp_if.kp_col, 4'b1110);
        goto(500);
        check("idle_press_cnt", 4'(press_cnt), 4'd0);
        check("idle_release_cnt", 4'(release_cnt), 4'd0);

        // '5' held from reset release: press 2 cycles after third frame's col-3 tick
        pressed = 16'(1) << K5;
        do_reset();
        goto(120); check("p5_early", {3'b0, kp_if.key_press}, 4'd0);
        goto(121); check("p5_press", {3'b0, kp_if.key_press}, 4'd1);
        check("p5_code", kp_if.key_code, 4'h5);
        check("p5_valid", {3'b0, kp_if.key_valid}, 4'd1);
        goto(122); check("p5_pulse_end", {3'b0, kp_if.key_press}, 4'd0);

        // Roll 5 -> D with no gap
        goto(125); pressed = 16'(1) << KD;
        goto(240); check("roll_early", {3'b0, kp_if.key_release}, 4'd0);
        goto(241); check("roll_press", {3'b0, kp_if.key_press}, 4'd1);
        check("roll_release", {3'b0, kp_if.key_release}, 4'd1);
        check("roll_code", kp_if.key_code, 4'hD);
        check("roll_valid", {3'b0, kp_if.key_valid}, 4'd1);

        // Release D
        goto(250); pressed = 16'h0;
        goto(360); check("rel_still_valid", {3'b0, kp_if.key_valid}, 4'd1);
        goto(361); check("rel_release", {3'b0, kp_if.key_release}, 4'd1);
        check("rel_valid", {3'b0, kp_if.key_valid}, 4'd0);
        check("rel_code", kp_if.key_code, 4'hD);

        // '1' held, then '6' added: MULTI frames are ignored
        goto(370); pressed = 16'(1) << K1;
        goto(521); check("p1_press", {3'b0, kp_if.key_press}, 4'd1);
        check("p1_code", kp_if.key_code, 4'h1);
        goto(530); pressed = pressed | (16'(1) << K6);
        p0 = press_cnt; r0 = release_cnt;
        goto(700);
        check("multi_press_cnt", 4'(press_cnt - p0), 4'd0);
        check("multi_release_cnt", 4'(release_cnt - r0), 4'd0);
        check("multi_code", kp_if.key_code, 4'h1);
        check("multi_valid", {3'b0, kp_if.key_valid}, 4'd1);

        // Reset in the middle of column 2 while 'A' is held
        pressed = 16'(1) << KA;
        goto(745);
        p0 = press_cnt; r0 = release_cnt;
        reset = 1'b1;
        #1;
        check("rst_col", kp_if.kp_col, 4'b1110);
        check("rst_valid", {3'b0, kp_if.key_valid}, 4'd0);
        check("rst_code", kp_if.key_code, 4'h0);
        check("rst_press", {3'b0, kp_if.key_press}, 4'd0);
        check("rst_release", {3'b0, kp_if.key_release}, 4'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        goto(120);
        check("rst_no_pulses", 4'(press_cnt - p0 + release_cnt - r0), 4'd0);
        goto(121); check("pA_press", {3'b0, kp_if.key_press}, 4'd1);
        check("pA_code", kp_if.key_code, 4'hA);
        check("pA_valid", {3'b0, kp_if.key_valid}, 4'd1);

        // Bounce on '5' for two frames, then steady
        pressed = 16'h0;
        do_reset();
        p0 = press_cnt;
        for (int k = 1; k <= 11; k++) begin
            goto(7 * k);
            pressed = pressed ^ (16'(1) << K5);
        end
        goto(80); pressed = 16'(1) << K5;
        goto(200); check("bounce_no_early", 4'(press_cnt - p0), 4'd0);
        goto(201); check("bounce_press", {3'b0, kp_if.key_press}, 4'd1);
        check("bounce_code", kp_if.key_code, 4'h5);
        goto(300); check("bounce_one_press", 4'(press_cnt - p0), 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
